moore_match_monitor: RTL and testbench

- Downstream consumer of the 11011 non-overlapping Moore detector output `d`.
- Turns the detector's level output into single-cycle match events.
- Keeps a saturating match count and measures the gap between consecutive matches.
- Raises a sticky burst alarm when THRESH matches land inside a WIN-cycle window; status is read by the surrounding test/debug logic.

---
 rtl/moore_mon_pkg.sv | 15 +
 rtl/moore_match_monitor_sat_counter.sv | 30 +++
 rtl/moore_match_monitor.sv | 159 +++++++++++++++
 tb/tb_moore_match_monitor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moore_mon_pkg.sv
// Shared types and default tuning for the 11011 match monitor.
package moore_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALARM = 2'd2
  } mon_state_t;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_GAP_W  = 8;
  localparam int DEF_WIN    = 16;
  localparam int DEF_THRESH = 3;

endpackage

// File: rtl/moore_match_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and load; clear beats load beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (ld) begin
      q_reg <= ld_val;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/moore_match_monitor.sv
// Converts the detector level into match events, counts them, times the gaps
// between them and raises a sticky alarm on THRESH matches inside a WIN-cycle window.
module moore_match_monitor
  import moore_mon_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int WIN    = DEF_WIN,
  parameter int THRESH = DEF_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             clr,
  output logic             evt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [GAP_W-1:0] last_gap,
  output logic             gap_vld,
  output logic             alarm
);

  localparam int WT_W = (WIN > 2) ? $clog2(WIN) : 1;
  localparam int WC_W = $clog2(THRESH + 1);

  mon_state_t       state_reg;
  logic             d_q_reg;
  logic             evt_reg;
  logic             alarm_reg;
  logic             gap_vld_reg;
  logic             seen_reg;
  logic [GAP_W-1:0] last_gap_reg;
  logic [WT_W-1:0]  win_tmr_reg;
  logic [GAP_W-1:0] gap_tmr;
  logic [GAP_W-1:0] gap_next;
  logic [WC_W-1:0]  win_cnt;

  logic det;
  logic armed;
  logic win_close;
  logic win_hit;
  logic win_cnt_clr;
  logic win_cnt_ld;
  logic win_cnt_inc;

  // d_q keeps tracking d through clr so a held level never re-counts afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q_reg <= 1'b0;
    end else begin
      d_q_reg <= d;
    end
  end

  assign det   = d & ~d_q_reg;
  assign armed = (state_reg == ARMED);

  // The closing edge is the one on which the window timer would reach WIN-1.
  assign win_close = armed && (win_tmr_reg == WT_W'(WIN - 2));
  assign win_hit   = armed && det && (win_cnt == WC_W'(THRESH - 1));

  assign win_cnt_clr = clr | (win_close & ~det);
  assign win_cnt_ld  = det & ((state_reg == IDLE) | (win_close & ~win_hit));
  assign win_cnt_inc = det & armed;

  assign gap_next = (gap_tmr == {GAP_W{1'b1}}) ? gap_tmr : gap_tmr + 1'b1;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .ld     (1'b0),
    .ld_val ({CNT_W{1'b0}}),
    .inc    (det),
    .q      (match_cnt)
  );

  sat_counter #(.W(GAP_W)) u_gap_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr | det),
    .ld     (1'b0),
    .ld_val ({GAP_W{1'b0}}),
    .inc    (seen_reg),
    .q      (gap_tmr)
  );

  sat_counter #(.W(WC_W)) u_win_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (win_cnt_clr),
    .ld     (win_cnt_ld),
    .ld_val (WC_W'(1)),
    .inc    (win_cnt_inc),
    .q      (win_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      evt_reg      <= 1'b0;
      alarm_reg    <= 1'b0;
      gap_vld_reg  <= 1'b0;
      seen_reg     <= 1'b0;
      last_gap_reg <= '0;
      win_tmr_reg  <= '0;
    end else if (clr) begin
      state_reg    <= IDLE;
      evt_reg      <= 1'b0;
      alarm_reg    <= 1'b0;
      gap_vld_reg  <= 1'b0;
      seen_reg     <= 1'b0;
      last_gap_reg <= '0;
      win_tmr_reg  <= '0;
    end else begin
      evt_reg <= det;
      if (det) begin
        seen_reg <= 1'b1;
        if (seen_reg) begin
          last_gap_reg <= gap_next;
          gap_vld_reg  <= 1'b1;
        end
      end
      case (state_reg)
        IDLE: begin
          if (det) begin
            state_reg   <= ARMED;
            win_tmr_reg <= '0;
          end
        end
        ARMED: begin
          if (win_hit) begin
            state_reg <= ALARM;
            alarm_reg <= 1'b1;
          end else if (win_close) begin
            // A match on the closing edge opens the next window directly.
            win_tmr_reg <= '0;
            if (!det) begin
              state_reg <= IDLE;
            end
          end else begin
            win_tmr_reg <= win_tmr_reg + 1'b1;
          end
        end
        ALARM: begin
          alarm_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign evt      = evt_reg;
  assign last_gap = last_gap_reg;
  assign gap_vld  = gap_vld_reg;
  assign alarm    = alarm_reg;

endmodule

// File: tb/tb_moore_match_monitor.sv
// Directed self-checking bench for moore_match_monitor (WIN=16, THRESH=3).
module tb_moore_match_monitor;

  logic       clk;
  logic       rst;
  logic       d;
  logic       clr;
  logic       evt;
  logic [7:0] match_cnt;
  logic [7:0] last_gap;
  logic       gap_vld;
  logic       alarm;

  logic       evt2;
  logic [1:0] match_cnt2;
  logic [7:0] last_gap2;
  logic       gap_vld2;
  logic       alarm2;

  int checks = 0;
  int errors = 0;

  moore_match_monitor #(.CNT_W(8), .GAP_W(8), .WIN(16), .THRESH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .clr       (clr),
    .evt       (evt),
    .match_cnt (match_cnt),
    .last_gap  (last_gap),
    .gap_vld   (gap_vld),
    .alarm     (alarm)
  );

  moore_match_monitor #(.CNT_W(2), .GAP_W(8), .WIN(16), .THRESH(3)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .clr       (clr),
    .evt       (evt2),
    .match_cnt (match_cnt2),
    .last_gap  (last_gap2),
    .gap_vld   (gap_vld2),
    .alarm     (alarm2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    d   = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Detection edge lands n edges after the previous tick (n >= 2); d is left low.
  task automatic event_in(input int n);
    d = 1'b0;
    repeat (n - 1) tick();
    d = 1'b1;
    tick();
    d = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; d = 1'b0; clr = 1'b0;
    #2;
    checks++;
    if (match_cnt !== 8'd0 || evt !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: match_cnt=%0d evt=%0b alarm=%0b required 0/0/0", match_cnt, evt, alarm);
    end
    #8;
    checks++;
    if (last_gap !== 8'd0 || gap_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_gap: last_gap=%0d gap_vld=%0b required 0/0", last_gap, gap_vld);
    end
    rst = 1'b1;
    tick();
    $display("reset: match_cnt=%0d alarm=%0b", match_cnt, alarm);
  endtask

  task automatic test_single_pulse();
    clr_all();
    event_in(3);
    checks++;
    if (evt !== 1'b1 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_evt: evt=%0b match_cnt=%0d required 1/1", evt, match_cnt);
    end
    tick();
    checks++;
    if (evt !== 1'b0 || gap_vld !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL single_after: evt=%0b gap_vld=%0b alarm=%0b required 0/0/0", evt, gap_vld, alarm);
    end
    $display("single_pulse: match_cnt=%0d evt=%0b", match_cnt, evt);
  endtask

  task automatic test_level_hold();
    int n = 0;
    clr_all();
    d = 1'b1;
    repeat (5) begin
      tick();
      if (evt === 1'b1) n++;
    end
    d = 1'b0;
    repeat (2) begin
      tick();
      if (evt === 1'b1) n++;
    end
    checks++;
    if (n != 1 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL level_hold: evts=%0d match_cnt=%0d required 1/1", n, match_cnt);
    end
    $display("level_hold: evts=%0d match_cnt=%0d", n, match_cnt);
  endtask

  task automatic test_gap();
    clr_all();
    event_in(2);
    checks++;
    if (gap_vld !== 1'b0) begin
      errors++;
      $display("FAIL gap_first: gap_vld=%0b required 0", gap_vld);
    end
    event_in(5);
    checks++;
    if (last_gap !== 8'd5 || gap_vld !== 1'b1) begin
      errors++;
      $display("FAIL gap_5: last_gap=%0d gap_vld=%0b required 5/1", last_gap, gap_vld);
    end
    event_in(300);
    checks++;
    if (last_gap !== 8'd255) begin
      errors++;
      $display("FAIL gap_sat: last_gap=%0d required 255", last_gap);
    end
    $display("gap: last_gap=%0d gap_vld=%0b", last_gap, gap_vld);
  endtask

  task automatic test_burst();
    clr_all();
    event_in(2);
    event_in(4);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL burst_early: alarm=%0b required 0", alarm);
    end
    event_in(4);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL burst_trip: alarm=%0b required 1", alarm);
    end
    repeat (40) tick();
    event_in(3);
    checks++;
    if (alarm !== 1'b1 || match_cnt !== 8'd4 || last_gap !== 8'd43) begin
      errors++;
      $display("FAIL burst_sticky: alarm=%0b match_cnt=%0d last_gap=%0d required 1/4/43", alarm, match_cnt, last_gap);
    end
    $display("burst: alarm=%0b match_cnt=%0d last_gap=%0d", alarm, match_cnt, last_gap);
  endtask

  task automatic test_window();
    // Match on the closing edge reopens the window with a count of one.
    clr_all();
    event_in(2);
    event_in(15);
    event_in(2);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL window_reopen: alarm=%0b required 0", alarm);
    end
    event_in(2);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL window_third: alarm=%0b required 1", alarm);
    end
    // Window fully expired before the second match.
    clr_all();
    event_in(2);
    event_in(16);
    event_in(2);
    checks++;
    if (alarm !== 1'b0 || match_cnt !== 8'd3) begin
      errors++;
      $display("FAIL window_expire: alarm=%0b match_cnt=%0d required 0/3", alarm, match_cnt);
    end
    $display("window: alarm=%0b match_cnt=%0d", alarm, match_cnt);
  endtask

  task automatic test_clr();
    clr_all();
    event_in(2);
    event_in(2);
    event_in(2);
    d   = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (evt !== 1'b0 || match_cnt !== 8'd0 || alarm !== 1'b0 || gap_vld !== 1'b0 || last_gap !== 8'd0) begin
      errors++;
      $display("FAIL clr_coincident: evt=%0b cnt=%0d alarm=%0b vld=%0b gap=%0d required all 0",
               evt, match_cnt, alarm, gap_vld, last_gap);
    end
    tick();
    checks++;
    if (evt !== 1'b0 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_held_level: evt=%0b match_cnt=%0d required 0/0", evt, match_cnt);
    end
    d = 1'b0;
    tick();
    $display("clr: match_cnt=%0d alarm=%0b", match_cnt, alarm);
  endtask

  task automatic test_saturation();
    clr_all();
    repeat (5) event_in(2);
    checks++;
    if (match_cnt2 !== 2'd3 || match_cnt !== 8'd5) begin
      errors++;
      $display("FAIL saturation: narrow=%0d wide=%0d required 3/5", match_cnt2, match_cnt);
    end
    $display("saturation: narrow=%0d wide=%0d", match_cnt2, match_cnt);
  endtask

  task automatic test_async_reset();
    clr_all();
    event_in(2);
    event_in(3);
    checks++;
    if (match_cnt !== 8'd2 || gap_vld !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: match_cnt=%0d gap_vld=%0b required 2/1", match_cnt, gap_vld);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (match_cnt !== 8'd0 || gap_vld !== 1'b0 || last_gap !== 8'd0 || evt !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d vld=%0b gap=%0d evt=%0b alarm=%0b required all 0",
               match_cnt, gap_vld, last_gap, evt, alarm);
    end
    #2;
    rst = 1'b1;
    tick();
    $display("async_reset: match_cnt=%0d gap_vld=%0b", match_cnt, gap_vld);
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_level_hold();
    test_gap();
    test_burst();
    test_window();
    test_clr();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
